surfboard_operand_loader: RTL and testbench



---
 rtl/surfboard_operand_loader_if.sv | 14 +
 rtl/surfboard_operand_loader.sv | 90 +++++++++
 tb/tb_surfboard_operand_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/surfboard_operand_loader_if.sv
// surfboard_operand_loader_if: element stream in, A/B operand pair out, with framing error flag.
interface surfboard_operand_loader_if #(parameter int W = 2);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic in_last;
  logic [0:3][W-1:0] A;
  logic [0:3][W-1:0] B;
  logic out_valid;
  logic out_ready;
  logic frame_err;
  modport master(output in_valid, in_data, in_last, out_ready, input in_ready, A, B, out_valid, frame_err);
  modport slave(input in_valid, in_data, in_last, out_ready, output in_ready, A, B, out_valid, frame_err);
endinterface

// File: rtl/surfboard_operand_loader.sv
// surfboard_operand_loader: frames an 8-element stream into row-major 2x2 operands A and B.
module surfboard_operand_loader #(parameter int W = 2) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  surfboard_operand_loader_if.slave bus
);
  localparam logic [1:0] LOAD = 2'd0, RESYNC = 2'd1, HOLD = 2'd2;
  logic [1:0] state, state_nx;
  logic [2:0] k, k_nx;
  logic rdy_nx, ov_nx, err_nx;
  logic acc, in_load, short_f, long_f, cap;
  assign acc = bus.in_valid & bus.in_ready;
  assign in_load = acc & (state == LOAD);
  assign short_f = in_load & bus.in_last & (k != 3'd7);
  assign long_f = in_load & ~bus.in_last & (k == 3'd7);
  assign cap = in_load & ~short_f & ~long_f & ~flush;
  always_comb begin
    state_nx = state;
    k_nx = k;
    rdy_nx = bus.in_ready;
    ov_nx = bus.out_valid;
    err_nx = 1'b0;
    if (flush) begin
      state_nx = LOAD;
      k_nx = 3'd0;
      rdy_nx = 1'b1;
      ov_nx = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          rdy_nx = 1'b1;
          if (short_f || long_f) begin
            k_nx = 3'd0;
            err_nx = 1'b1;
            state_nx = long_f ? RESYNC : LOAD;
          end else if (cap) begin
            k_nx = k + 3'd1;
            if (k == 3'd7) begin
              state_nx = HOLD;
              rdy_nx = 1'b0;
              ov_nx = 1'b1;
            end
          end
        end
        RESYNC: begin
          rdy_nx = 1'b1;
          if (acc && bus.in_last) begin
            state_nx = LOAD;
            k_nx = 3'd0;
          end
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            state_nx = LOAD;
            k_nx = 3'd0;
            rdy_nx = 1'b1;
            ov_nx = 1'b0;
          end
        end
        default: begin
          state_nx = LOAD;
          k_nx = 3'd0;
          rdy_nx = 1'b1;
          ov_nx = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      k <= 3'd0;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.A <= '0;
      bus.B <= '0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      bus.in_ready <= rdy_nx;
      bus.out_valid <= ov_nx;
      bus.frame_err <= err_nx;
      // first four beats fill A, the next four fill B, each at its row-major slot
      if (cap && !k[2]) bus.A[k[1:0]] <= bus.in_data;
      if (cap && k[2]) bus.B[k[1:0]] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_surfboard_operand_loader.sv
// tb_surfboard_operand_loader: directed and random streams checked every cycle against a beat-counting model.
module tb_surfboard_operand_loader;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  surfboard_operand_loader_if #(.W(W)) bus();
  surfboard_operand_loader #(.W(W)) dut(.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic m_rdy, m_ov, m_err;
  logic [0:3][W-1:0] ma, mb;
  int m_n;
  bit m_rs;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    chk("A", 32'(bus.A), 32'(ma));
    chk("B", 32'(bus.B), 32'(mb));
  endtask
  task automatic model_reset();
    m_rdy = 0; m_ov = 0; m_err = 0; ma = '0; mb = '0; m_n = 0; m_rs = 0;
  endtask
  // one clock edge worth of the frame rules, applied to whatever inputs are currently driven
  task automatic advance();
    bit acc;
    acc = bus.in_valid && m_rdy;
    m_err = 0;
    if (flush) begin
      m_n = 0; m_rs = 0; m_ov = 0; m_rdy = 1;
    end else if (m_ov) begin
      if (bus.out_ready) begin m_ov = 0; m_rdy = 1; m_n = 0; end
    end else begin
      m_rdy = 1;
      if (acc) begin
        if (m_rs) begin
          if (bus.in_last) m_rs = 0;
        end else if (bus.in_last && m_n < 7) begin
          m_err = 1; m_n = 0;
        end else if (m_n == 7 && !bus.in_last) begin
          m_err = 1; m_rs = 1; m_n = 0;
        end else begin
          if (m_n < 4) ma[m_n] = bus.in_data;
          else mb[m_n-4] = bus.in_data;
          m_n++;
          if (m_n == 8) begin m_ov = 1; m_rdy = 0; end
        end
      end
    end
  endtask
  task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit ord, input bit fl, output bit acc);
    @(negedge clk);
    check_all();
    bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.out_ready = ord; flush = fl;
    acc = v && m_rdy;
    advance();
  endtask
  task automatic idle(input int n, input bit ord);
    bit a;
    repeat (n) step(0, '0, 0, ord, 0, a);
  endtask
  task automatic send(input logic [0:15][W-1:0] f, input int n, input bit ord);
    int i = 0;
    int budget = 0;
    bit a;
    while (i < n && budget < 200) begin
      step(1, f[i], i == n - 1, ord, 0, a);
      if (a) i++;
      budget++;
    end
    chk("send_done", 32'(i), 32'(n));
  endtask
  task automatic release_reset();
    @(negedge clk);
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0; flush = 0;
    rst_n = 1;
    advance();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit a;
    int i;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    model_reset();
    #12;
    check_all();
    release_reset();
    send({2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 16'h0}, 8, 1);
    idle(3, 1);
    send({2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 16'h0}, 8, 0);
    repeat (5) step(1, 2'd3, 0, 0, 0, a);
    step(0, '0, 0, 1, 0, a);
    idle(2, 1);
    send({2'd1, 2'd1, 2'd1, 2'd1, 24'h0}, 4, 1);
    send({2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 16'h0}, 8, 0);
    idle(2, 0);
    idle(2, 1);
    send({2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 12'h0}, 10, 1);
    send({2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 16'h0}, 8, 1);
    idle(2, 1);
    for (i = 0; i < 5; i++) step(1, 2'(i + 1), 0, 1, 0, a);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    release_reset();
    send({2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 16'h0}, 8, 1);
    idle(2, 1);
    for (i = 0; i < 3; i++) step(1, 2'd3, 0, 1, 0, a);
    step(1, 2'd1, 0, 1, 1, a);
    step(0, '0, 0, 1, 0, a);
    send({2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 16'h0}, 8, 1);
    idle(2, 1);
    i = 0;
    for (int c = 0; c < 40 && i < 8; c++) begin
      step(c % 2 == 0, 2'(i + c), i == 7, 1, 0, a);
      if (a) i++;
    end
    chk("toggle_done", 32'(i), 32'd8);
    idle(3, 1);
    repeat (1500) begin
      bit l;
      l = (m_n == 7) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 3) != 0, W'($urandom), l, $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0, a);
    end
    @(negedge clk);
    check_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
